// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter that owns a shared 4:1 single-bit mux.
// Optional tenure timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter_rr #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  output logic [3:0] grant,
  output logic       address0,
  output logic       address1,
  output logic       out,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [3:0] ins;
  logic [2:0] from_ptr;
  logic [2:0] from_next;
  logic       expire;
  logic       release_now;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux_arbiter_rr: HOLD_MAX must be in 2..255");
  end

  assign ins = {in3, in2, in1, in0};

  // First requester found searching upward from start; {found, index}.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] start
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign from_ptr    = pick(req, ptr);
  assign from_next   = pick(req, owner + 2'd1);
  assign release_now = (state == OWNED) && (!req[owner] || expire);

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic       at_max;
  logic       others;

  assign at_max = (cnt == 8'(HOLD_MAX - 1));
  assign others = |(req & ~(4'b0001 << owner));
  assign expire = at_max && others;

  // Tenure counter: cleared on every new grant, wraps when nobody waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (state == IDLE || release_now) begin
      cnt <= 8'd0;
    end else if (at_max) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Ownership FSM: grant, owner and pointer all move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      grant <= 4'b0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (from_ptr[2]) begin
            state <= OWNED;
            owner <= from_ptr[1:0];
            grant <= 4'b0001 << from_ptr[1:0];
            ptr   <= from_ptr[1:0] + 2'd1;
          end
        end
        OWNED: begin
          if (release_now) begin
            if (from_next[2]) begin
              owner <= from_next[1:0];
              grant <= 4'b0001 << from_next[1:0];
              ptr   <= from_next[1:0] + 2'd1;
            end else begin
              state <= IDLE;
              owner <= 2'd0;
              grant <= 4'b0000;
            end
          end
        end
      endcase
    end
  end

  // Owner index doubles as mux select; it is held at 0 while idle.
  assign busy     = (state == OWNED);
  assign address0 = owner[0];
  assign address1 = owner[1];
  assign out      = busy & ins[owner];

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Scoreboard bench for mux_arbiter_rr with a queue-based reference model.
// Directed scenarios plus randomized request/data traffic.
module tb_mux_arbiter_rr;

  localparam int HM = 8;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       in0, in1, in2, in3;
  logic [3:0] grant;
  logic       address0, address1, out, busy;

  mux_arbiter_rr #(.HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant), .address0(address0), .address1(address1),
    .out(out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] a;
    logic       b;
    logic       o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int s);
    for (int k = 0; k < 4; k++)
      if (r[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  function automatic void m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endfunction

  function automatic void m_take(input int o);
    if (o < 0) begin
      m_owner = -1;
    end else begin
      m_owner = o;
      m_ptr   = (o + 1) % 4;
      m_held  = 1;
    end
  endfunction

  function automatic void m_step(input logic [3:0] r);
    logic [3:0] rest;
    bit rot;
    if (m_owner < 0) begin
      m_take(first_from(r, m_ptr));
    end else begin
      rot = !r[m_owner];
      rest = r;
      rest[m_owner] = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_held == HM && rest != 4'b0) rot = 1'b1;
`endif
      if (rot) m_take(first_from(rest, (m_owner + 1) % 4));
`ifdef MUX_ARB_TIMEOUT_EN
      else m_held = (m_held == HM) ? 1 : m_held + 1;
`else
      else m_held = m_held + 1;
`endif
    end
  endfunction

  function automatic exp_t m_expect(input logic [3:0] ins);
    exp_t e;
    if (m_owner < 0) begin
      e = '0;
    end else begin
      e.g = 4'b0001 << m_owner;
      e.a = 2'(m_owner);
      e.b = 1'b1;
      e.o = ins[m_owner];
    end
    return e;
  endfunction

  task automatic drive(input logic [3:0] r, input logic [3:0] ins);
    req = r;
    {in3, in2, in1, in0} = ins;
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] ins);
    drive(r, ins);
    m_step(r);
    q.push_back(m_expect(ins));
    @(negedge clk);
  endtask

  task automatic reset_pulse(input logic [3:0] r, input logic [3:0] ins);
    drive(r, ins);
    #2 reset = 1'b1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);
    chk("rst_addr", {address1, address0}, 0);
    #1 reset = 1'b0;
    m_reset();
    m_step(r);
    q.push_back(m_expect(ins));
    @(negedge clk);
  endtask

  // Monitor: every cycle with a pending expectation is compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_grant", grant, e.g);
        chk("mon_addr", {address1, address0}, e.a);
        chk("mon_busy", busy, e.b);
        chk("mon_out", out, e.o);
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] ins;
    logic [3:0] seq [8];
    logic       v;
    int         waitc;

    seq[0] = 4'b0001; seq[1] = 4'b0001;
    seq[2] = 4'b0010; seq[3] = 4'b0010;
    seq[4] = 4'b0100; seq[5] = 4'b0100;
    seq[6] = 4'b1000; seq[7] = 4'b1000;

    reset = 1'b1;
    drive(4'b1111, 4'b1111);
    #2;
    chk("init_grant", grant, 0);
    chk("init_busy", busy, 0);
    chk("init_out", out, 0);
    chk("init_addr", {address1, address0}, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();

    // Every owner drops after two cycles: back-to-back rotation.
    for (int i = 0; i < 8; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      cycle(r, 4'($urandom));
      chk("rot_seq", grant, seq[i]);
      chk("rot_busy", busy, 1);
    end

    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000);
    chk("idle_grant", grant, 0);

    // Single requester 2 with toggling data.
    v = 1'b0;
    cycle(4'b0100, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      v = ~v;
      in2 = v;
      #1;
      chk("mux_track", out, v);
      cycle(4'b0100, {1'b1, v, 2'b01});
      chk("mux_grant", grant, 4'b0100);
      chk("mux_addr", {address1, address0}, 2);
    end
    cycle(4'b0000, 4'b1111);
    chk("drop_grant", grant, 0);
    chk("drop_busy", busy, 0);
    chk("drop_out", out, 0);

    // Owner 1 releases with 0 and 3 pending, pointer at 2.
    cycle(4'b0010, 4'($urandom));
    cycle(4'b0010, 4'($urandom));
    chk("own1", grant, 4'b0010);
    cycle(4'b1001, 4'($urandom));
    chk("ptr_order", grant, 4'b1000);
    cycle(4'b1001, 4'($urandom));
    cycle(4'b0001, 4'($urandom));
    chk("wrap_to0", grant, 4'b0001);
    cycle(4'b0000, 4'($urandom));

    // Mid-tenure reset, then first grant from pointer 0.
    cycle(4'b1111, 4'($urandom));
    cycle(4'b1111, 4'($urandom));
    reset_pulse(4'b1111, 4'($urandom));
    chk("post_rst", grant, 4'b0001);

    // Random traffic with occasional resets and idle bursts.
    r = 4'($urandom);
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      if ($urandom_range(40) == 0) r = 4'b0000;
      ins = 4'($urandom);
      if (i % 400 == 399) reset_pulse(r, ins);
      else cycle(r, ins);
    end

    waitc = 0;
    while (q.size() > 0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_rr.md
MUX_ARBITER_RR -- requirements
Module: mux_arbiter_rr

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, meaning the maximum grant tenure in clock cycles when MUX_ARB_TIMEOUT_EN is defined (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, one request bit per requester 0..3, level-held while access to the shared mux is wanted.
REQ-005 The block SHALL have ports in0, in1, in2, in3, input, 1 each, the data bits of requesters 0..3.
REQ-006 The block SHALL have port grant, output, 4, one-hot (or all-zero) current owner.
REQ-007 The block SHALL have ports address0, address1, output, 1 each, the mux select (address1:address0 = owner index).
REQ-008 The block SHALL have port out, output, 1, the shared mux output.
REQ-009 The block SHALL have port busy, output, 1, high while any requester holds the grant.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and OWNED (exactly one owner).
REQ-011 The block SHALL hold a 2-bit round-robin pointer ptr; searches start at ptr and proceed ptr, ptr+1, ... mod 4.
REQ-012 In IDLE, on a rising edge with req != 0, the block SHALL grant the first requesting index found from ptr and enter OWNED; grant appears one cycle after req is sampled.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with grant = 0.
REQ-014 In OWNED, while req[owner] = 1 (and no timeout), the block SHALL keep the owner unchanged.
REQ-015 In OWNED, on an edge where req[owner] = 0, the block SHALL hand the grant directly to the next requester searched from owner+1 (no idle bubble), or enter IDLE if req == 0.
REQ-016 On every grant change the block SHALL set ptr = new owner + 1 mod 4; ptr SHALL be unchanged in IDLE.
REQ-017 address1:address0 SHALL equal the owner index in OWNED and 2'b00 in IDLE.
REQ-018 out SHALL equal the owner's input bit combinationally (in[address]) in OWNED and 0 in IDLE.
REQ-019 busy SHALL equal 1 exactly in OWNED; grant SHALL never have more than one bit set.
REQ-020 Simultaneous requests SHALL be resolved solely by ptr order; a requester that deasserts before being granted SHALL not be granted.

Reset
REQ-021 While reset is high, regardless of clk, the block SHALL force state = IDLE, ptr = 0, tenure counter = 0, grant = 4'b0000, address0 = address1 = 0, busy = 0, out = 0.
REQ-022 Reset asserted mid-tenure SHALL drop the grant immediately; after release the first grant follows REQ-012 from ptr = 0.

Configuration
REQ-023 With macro MUX_ARB_TIMEOUT_EN defined, the block SHALL count tenure cycles (counter cleared on each new grant); when the count reaches HOLD_MAX and any other req bit is set, the next edge SHALL rotate the grant per REQ-015 even though req[owner] = 1.
REQ-024 With MUX_ARB_TIMEOUT_EN defined and no other requester at HOLD_MAX, the owner SHALL keep the grant and the counter SHALL restart at 0.
REQ-025 Without MUX_ARB_TIMEOUT_EN, no tenure counter SHALL exist and an owner SHALL hold the grant until it deasserts req; HOLD_MAX is ignored.

Verification
REQ-026 Reset then req=4'b1111 held, owners drop req after 2 cycles each -> grant sequence 0001, 0010, 0100, 1000, back-to-back, no IDLE cycle.
REQ-027 req=4'b0100, in2 toggling 0/1 -> grant=0100, address1:address0=10, out tracks in2 same cycle, busy=1; req=0 -> next edge grant=0, out=0, busy=0.
REQ-028 Owner 1 releases with req=4'b1001 pending, ptr=2 -> grant=1000 next edge, then 0001 after 3 releases.
REQ-029 MUX_ARB_TIMEOUT_EN, HOLD_MAX=8, req=4'b0011 held forever -> grant alternates 0001/0010 every 8 cycles; req=4'b0001 alone -> grant stays 0001 indefinitely.
REQ-030 Assert reset for a half cycle mid-tenure with req=4'b1111 -> grant=0 asynchronously; after release grant=0001 on first edge.
